// File: rtl/adder_pipe_n.sv
// -----------------------------------------------------------------------------
// adder_pipe_n
//   Pipelined multi-operand adder. Each accepted beat carries N_OPS unsigned
//   operands and a carry-in. The beat total is either a fresh sum or is added to
//   the previous beat's result (running accumulation). The result wraps modulo
//   2^SUM_W (SAT=0) or clamps to 2^SUM_W-1 (SAT=1). An overflow flag reports
//   when the true total did not fit.
//
//   Pipeline: S1 registers two lossless half-sums plus cin/acc; S2 forms the
//   final total and registers sum/zero/overflow. Latency is 2 cycles; throughput
//   is 1 beat/cycle. Valid/ready handshakes on both sides.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous reset, active-high
//   in_valid   in   1            input beat valid
//   in_ready   out  1            beat accepted when in_valid & in_ready
//   in_ops     in   N_OPS*OP_W   operand k = in_ops[k*OP_W +: OP_W]
//   in_cin     in   1            carry-in (+1)
//   in_acc     in   1            1: add to previous result, 0: start fresh
//   out_valid  out  1            result valid
//   out_ready  in   1            result consumed when out_valid & out_ready
//   sum_r      out  SUM_W        registered result
//   sum_zero_r out  1            registered (sum_r == 0)
//   ovf_r      out  1            registered overflow flag
// -----------------------------------------------------------------------------
module adder_pipe_n #(
  parameter int N_OPS = 4,
  parameter int OP_W  = 8,
  parameter int SUM_W = 10,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_OPS*OP_W-1:0] in_ops,
  input  logic                  in_cin,
  input  logic                  in_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SUM_W-1:0]      sum_r,
  output logic                  sum_zero_r,
  output logic                  ovf_r
);

  // Half-sum width: enough to hold N_OPS full-scale operands without loss.
  localparam int PW   = OP_W + $clog2(N_OPS);
  localparam int N_LO = N_OPS / 2;
  // Total width: two half-sums + cin stay below 2^PW, accumulator below
  // 2^SUM_W, so one bit above the larger of the two always suffices.
  localparam int TW   = ((PW > SUM_W) ? PW : SUM_W) + 1;

  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  // ---------------------------------------------------------------------------
  // Operand unpacking and S1 half-sums
  // ---------------------------------------------------------------------------
  logic [OP_W-1:0] w_ops [N_OPS];

  genvar gi;
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_unpack
      assign w_ops[gi] = in_ops[gi*OP_W +: OP_W];
    end
  endgenerate

  logic [PW-1:0] w_p_lo;
  logic [PW-1:0] w_p_hi;

  always_comb begin
    w_p_lo = '0;
    w_p_hi = '0;
    for (int k = 0; k < N_OPS; k++) begin
      if (k < N_LO) w_p_lo = w_p_lo + PW'(w_ops[k]);
      else          w_p_hi = w_p_hi + PW'(w_ops[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_s2_adv;
  logic w_in_ready;

  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  // ---------------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_p_lo;
  logic [PW-1:0] r_p_hi;
  logic          r_cin;
  logic          r_acc_en;

  // ---------------------------------------------------------------------------
  // S2 combinational total
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] r_accum;
  logic [SUM_W-1:0] r_sum;
  logic             r_zero;
  logic             r_ovf;

  logic [TW-1:0]    w_total;
  logic             w_ovf;
  logic [SUM_W-1:0] w_sum;

  // The accumulator always holds the result of the beat that most recently
  // left S2, i.e. the immediately preceding beat, so back-to-back acc beats
  // chain correctly without any forwarding.
  always_comb begin
    w_total = TW'(r_p_lo) + TW'(r_p_hi) + TW'(r_cin);
    if (r_acc_en) w_total = w_total + TW'(r_accum);
    w_ovf = |w_total[TW-1:SUM_W];
    if (w_ovf && (SAT != 0)) w_sum = SUM_MAX;
    else                     w_sum = w_total[SUM_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_p_lo      <= '0;
      r_p_hi      <= '0;
      r_cin       <= 1'b0;
      r_acc_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_accum     <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_p_lo   <= w_p_lo;
          r_p_hi   <= w_p_hi;
          r_cin    <= in_cin;
          r_acc_en <= in_acc;
        end
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        // Result registers only change on a real load so they hold their
        // last value through bubbles and stalls.
        if (r_s1_valid) begin
          r_sum   <= w_sum;
          r_zero  <= (w_sum == '0);
          r_ovf   <= w_ovf;
          r_accum <= w_sum;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign sum_r      = r_sum;
  assign sum_zero_r = r_zero;
  assign ovf_r      = r_ovf;

endmodule

// File: tb/tb_adder_pipe_n.sv
module tb_adder_pipe_n;

  localparam int N_OPS = 4;
  localparam int OP_W  = 8;
  localparam int SUM_W = 10;
  localparam int MAXV  = (1 << SUM_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  in_valid  = 1'b0;
  logic [N_OPS*OP_W-1:0] in_ops    = '0;
  logic                  in_cin    = 1'b0;
  logic                  in_acc    = 1'b0;
  logic                  out_ready = 1'b1;

  logic             in_ready0, out_valid0, sum_zero_r0, ovf_r0;
  logic [SUM_W-1:0] sum_r0;
  logic             in_ready1, out_valid1, sum_zero_r1, ovf_r1;
  logic [SUM_W-1:0] sum_r1;

  // Wrapping instance
  adder_pipe_n #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W), .SAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ops(in_ops), .in_cin(in_cin), .in_acc(in_acc),
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum_r(sum_r0), .sum_zero_r(sum_zero_r0), .ovf_r(ovf_r0)
  );

  // Saturating instance, same stimulus
  adder_pipe_n #(.N_OPS(N_OPS), .OP_W(OP_W), .SUM_W(SUM_W), .SAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ops(in_ops), .in_cin(in_cin), .in_acc(in_acc),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum_r(sum_r1), .sum_zero_r(sum_zero_r1), .ovf_r(ovf_r1)
  );

  typedef struct {
    int s0; int o0;   // wrap result / overflow
    int s1; int o1;   // clamp result / overflow
  } exp_t;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic       cin, acc;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   macc0 = 0;
  int   macc1 = 0;
  logic use_tbl = 1'b0;
  exp_t tbl_exp;
  int   rdy_mode = 0;   // 0: ready, 1: random, 2: stalled
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard and reference model: results in acceptance order.
  exp_t m_e;
  exp_t h_e;
  int   m_t;
  int   m_t0;
  int   m_t1;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      macc0 = 0;
      macc1 = 0;
    end else begin
      if (out_valid0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          h_e = exp_q[0];
          chk("sum_wrap",  int'(sum_r0),      h_e.s0);
          chk("zero_wrap", int'(sum_zero_r0), int'(h_e.s0 == 0));
          chk("ovf_wrap",  int'(ovf_r0),      h_e.o0);
          chk("valid_sat", int'(out_valid1),  1);
          chk("sum_sat",   int'(sum_r1),      h_e.s1);
          chk("zero_sat",  int'(sum_zero_r1), int'(h_e.s1 == 0));
          chk("ovf_sat",   int'(ovf_r1),      h_e.o1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready0) begin
        if (use_tbl) begin
          m_e = tbl_exp;
        end else begin
          m_t = int'(in_cin);
          for (int k = 0; k < N_OPS; k++) m_t += int'(in_ops[k*OP_W +: OP_W]);
          m_t0   = m_t + (in_acc ? macc0 : 0);
          m_t1   = m_t + (in_acc ? macc1 : 0);
          m_e.o0 = int'(m_t0 > MAXV);
          m_e.s0 = m_t0 % (MAXV + 1);
          m_e.o1 = int'(m_t1 > MAXV);
          m_e.s1 = (m_t1 > MAXV) ? MAXV : m_t1;
        end
        macc0 = m_e.s0;
        macc1 = m_e.s1;
        exp_q.push_back(m_e);
      end
    end
  end

  // Present one beat (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [7:0] a, b, c, d, input logic cin, acc,
                      input logic tbl_mode, input exp_t e);
    int n;
    in_ops   = {d, c, b, a};
    in_cin   = cin;
    in_acc   = acc;
    use_tbl  = tbl_mode;
    tbl_exp  = e;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rnd_op();
    if ($urandom_range(0, 3) == 0) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  exp_t none;
  initial begin
    int n;
    int got;
    logic acc_now;
    none = '{0, 0, 0, 0};

    //            a    b    c    d   cin  acc   s0  o0   s1  o1
    tbl[0] = '{8'd1,  8'd2,  8'd3,  8'd4,  1'b1, 1'b0, '{11,   0, 11,   0}};
    tbl[1] = '{8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 1'b0, '{0,    0, 0,    0}};
    tbl[2] = '{8'd255,8'd255,8'd255,8'd255,1'b1, 1'b0, '{1021, 0, 1021, 0}};
    tbl[3] = '{8'd1,  8'd1,  8'd1,  8'd0,  1'b0, 1'b1, '{0,    1, 1023, 1}};
    tbl[4] = '{8'd5,  8'd0,  8'd0,  8'd0,  1'b0, 1'b0, '{5,    0, 5,    0}};
    tbl[5] = '{8'd1,  8'd0,  8'd0,  8'd0,  1'b0, 1'b1, '{6,    0, 6,    0}};
    tbl[6] = '{8'd1,  8'd0,  8'd0,  8'd0,  1'b0, 1'b1, '{7,    0, 7,    0}};
    tbl[7] = '{8'd1,  8'd0,  8'd0,  8'd0,  1'b0, 1'b1, '{8,    0, 8,    0}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_sum",       int'(sum_r0),     0);
    chk("rst_zero",      int'(sum_zero_r0), 0);
    chk("rst_ovf",       int'(ovf_r0),     0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready0), 1);

    // Latency of the first beat: accepted on one edge, valid after the next.
    send(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, tbl[0].cin, tbl[0].acc, 1'b1, tbl[0].e);
    n = 0;
    while (!out_valid0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n + 1, 2);
    drain("drain_basic");

    // Table vectors, back to back
    for (int i = 1; i < 8; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].cin, tbl[i].acc, 1'b1, tbl[i].e);
    drain("drain_table");

    // Back-pressure: stall the output, keep offering beats
    rdy_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    use_tbl  = 1'b0;
    in_ops   = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
    in_cin   = 1'($urandom);
    in_acc   = 1'($urandom);
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc_now = in_ready0;
      if (acc_now) got++;
      @(posedge clk);
      #1;
      if (acc_now) begin
        in_ops = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
        in_cin = 1'($urandom);
        in_acc = 1'($urandom);
      end
    end
    chk("bp_accepted", got, 2);
    chk("bp_in_ready", int'(in_ready0), 0);
    chk("bp_out_valid", int'(out_valid0), 1);
    rdy_mode = 0;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_resume", int'(n < 20), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("drain_bp");

    // Random stream with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0, none);
    end
    rdy_mode = 0;
    drain("drain_random");

    // Reset mid-stream: asynchronous clear, then accumulator must be zero
    rdy_mode = 1;
    use_tbl  = 1'b0;
    in_ops   = {8'd9, 8'd8, 8'd7, 8'd6};
    in_cin   = 1'b1;
    in_acc   = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid0), 0);
    chk("arst_sum",       int'(sum_r0),     0);
    chk("arst_zero",      int'(sum_zero_r0), 0);
    chk("arst_ovf",       int'(ovf_r0),     0);
    chk("arst_sum_sat",   int'(sum_r1),     0);
    rdy_mode = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_in_ready", int'(in_ready0), 1);
    send(8'd3, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, '{3, 0, 3, 0});
    drain("drain_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
